// File: rtl/spi_master_multi.sv
// SPI master with runtime CPOL/CPHA, programmable SCK half-period and NUM_CS chip selects.
// Configuration is captured when a transfer is accepted and held until it completes.
module spi_master_multi #(
  parameter  int DATA_W = 8,
  parameter  int NUM_CS = 4,
  parameter  int DIV_W  = 8,
  localparam int SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              I_start,
  input  logic              I_cpol,
  input  logic              I_cpha,
  input  logic [SEL_W-1:0]  I_cs_sel,
  input  logic [DIV_W-1:0]  I_div,
  input  logic [DATA_W-1:0] I_tx_data,
  output logic [DATA_W-1:0] O_rx_data,
  output logic              O_busy,
  output logic              O_done,
  input  logic              I_spi_miso,
  output logic              O_spi_sck,
  output logic [NUM_CS-1:0] O_spi_cs_n,
  output logic              O_spi_mosi
);

  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL
  } state_t;

  state_t            state_q, state_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [NUM_CS-1:0] cs_sel_n;
  logic              tick;
  logic              fire;
  logic [EDGE_W-1:0] edge_num;
  logic              sample_edge;
  logic              shift_edge;

  // An out-of-range select simply matches no line, leaving every CS high.
  always_comb begin
    cs_sel_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (32'(I_cs_sel) == 32'(i)) cs_sel_n[i] = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fire        = 1'b0;
    edge_num    = '0;
    sample_edge = 1'b0;
    shift_edge  = 1'b0;
    tick        = (cnt_q == div_q);

    case (state_q)
      IDLE: begin
        sck_d  = I_cpol;
        cs_n_d = '1;
        if (I_start) begin
          state_d = LEAD;
          cpol_d  = I_cpol;
          cpha_d  = I_cpha;
          div_d   = I_div;
          cnt_d   = '0;
          edge_d  = '0;
          rx_sh_d = '0;
          cs_n_d  = cs_sel_n;
          busy_d  = 1'b1;
          if (I_cpha) begin
            tx_sh_d = I_tx_data;
          end else begin
            mosi_d  = I_tx_data[DATA_W-1];
            tx_sh_d = {I_tx_data[DATA_W-2:0], 1'b0};
          end
        end
      end
      LEAD: begin
        sck_d = cpol_q;
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          state_d  = XFER;
          fire     = 1'b1;
          edge_num = EDGE_W'(1);
        end
      end
      XFER: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          if (edge_q == LAST_EDGE) begin
            state_d = TRAIL;
          end else begin
            fire     = 1'b1;
            edge_num = edge_q + 1'b1;
          end
        end
      end
      TRAIL: begin
        sck_d = cpol_q;
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          state_d   = IDLE;
          cs_n_d    = '1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Odd edges are leading edges; CPHA picks which of leading/trailing samples.
    if (fire) begin
      edge_d      = edge_num;
      sck_d       = ~sck_q;
      sample_edge = cpha_q ? ~edge_num[0] : edge_num[0];
      shift_edge  = cpha_q ? edge_num[0] : (~edge_num[0] && (edge_num != LAST_EDGE));
      if (sample_edge) rx_sh_d = {rx_sh_q[DATA_W-2:0], I_spi_miso};
      if (shift_edge) begin
        mosi_d  = tx_sh_q[DATA_W-1];
        tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      cnt_q     <= '0;
      edge_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign O_rx_data  = rx_data_q;
  assign O_busy     = busy_q;
  assign O_done     = done_q;
  assign O_spi_sck  = sck_q;
  assign O_spi_mosi = mosi_q;
  assign O_spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: a bus monitor and slave model derive every expected value
// from the transfer rules (edge counts, H-cycle timing, MSB-first bit order).
module tb_spi_master_multi;

  localparam int DATA_W = 8;
  localparam int NUM_CS = 3;
  localparam int DIV_W  = 8;
  localparam int SEL_W  = 2;

  localparam int MISO_SLAVE = 0;
  localparam int MISO_LOOP  = 1;
  localparam int MISO_ONES  = 2;

  logic              clock;
  logic              reset;
  logic              start;
  logic              cpol;
  logic              cpha;
  logic [SEL_W-1:0]  cs_sel;
  logic [DIV_W-1:0]  div;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              spi_miso;
  logic              spi_sck;
  logic [NUM_CS-1:0] spi_cs_n;
  logic              spi_mosi;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave/monitor context for the transfer in flight.
  logic              cpha_m     = 1'b0;
  int                sel_m      = 0;
  logic [DATA_W-1:0] slave_word = '0;
  int                miso_mode  = MISO_SLAVE;
  logic              miso_slave = 1'b0;

  // Expected configuration of the transfer in flight.
  logic              exp_cpol = 1'b0;
  int                exp_div  = 0;
  int                exp_sel  = 0;
  logic [DATA_W-1:0] exp_tx   = '0;
  logic [DATA_W-1:0] exp_sw   = '0;
  int                exp_mode = MISO_SLAVE;

  int                cyc = 0;
  int                edges = 0;
  int                rise_cyc = 0;
  int                rise_count = 0;
  int                done_count = 0;
  int                cs_low_cyc = 0;
  int                cs_high_run = 0;
  int                last_gap = 0;
  logic              other_cs_low = 1'b0;
  logic [DATA_W-1:0] mosi_word = '0;
  logic              busy_prev = 1'b0;
  logic              sck_prev = 1'b0;

  int                last_latency = 0;
  int                last_edges = 0;
  int                last_cs_low = 0;
  logic              last_other_low = 1'b0;
  logic              last_sck = 1'b0;
  logic [DATA_W-1:0] last_rx = '0;
  logic [DATA_W-1:0] last_mosi_word = '0;

  assign spi_miso = (miso_mode == MISO_LOOP) ? spi_mosi :
                    (miso_mode == MISO_ONES) ? 1'b1 : miso_slave;

  spi_master_multi #(
    .DATA_W (DATA_W),
    .NUM_CS (NUM_CS),
    .DIV_W  (DIV_W)
  ) dut (
    .CLOCK      (clock),
    .RESET      (reset),
    .I_start    (start),
    .I_cpol     (cpol),
    .I_cpha     (cpha),
    .I_cs_sel   (cs_sel),
    .I_div      (div),
    .I_tx_data  (tx_data),
    .O_rx_data  (rx_data),
    .O_busy     (busy),
    .O_done     (done),
    .I_spi_miso (spi_miso),
    .O_spi_sck  (spi_sck),
    .O_spi_cs_n (spi_cs_n),
    .O_spi_mosi (spi_mosi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Bus monitor and slave: counts SCK edges, captures MOSI on sampling edges,
  // measures CS timing and presents the slave word MSB first.
  initial forever begin
    int idx;
    @(negedge clock);
    if (busy && !busy_prev) begin
      rise_cyc     = cyc;
      rise_count++;
      edges        = 0;
      mosi_word    = '0;
      cs_low_cyc   = 0;
      other_cs_low = 1'b0;
    end
    if (busy && (spi_sck != sck_prev)) begin
      edges++;
      if (cpha_m ? (edges % 2 == 0) : (edges % 2 == 1))
        mosi_word = {mosi_word[DATA_W-2:0], spi_mosi};
    end
    for (int i = 0; i < NUM_CS; i++) begin
      if (!spi_cs_n[i]) begin
        if (i == sel_m) cs_low_cyc++;
        else other_cs_low = 1'b1;
      end
    end
    if (sel_m < NUM_CS) begin
      if (spi_cs_n[sel_m]) begin
        cs_high_run++;
      end else begin
        if (cs_high_run > 0) last_gap = cs_high_run;
        cs_high_run = 0;
      end
    end
    if (done) begin
      done_count++;
      last_latency   = cyc - rise_cyc;
      last_rx        = rx_data;
      last_mosi_word = mosi_word;
      last_edges     = edges;
      last_cs_low    = cs_low_cyc;
      last_other_low = other_cs_low;
      last_sck       = spi_sck;
    end
    busy_prev = busy;
    sck_prev  = spi_sck;
    idx = cpha_m ? ((edges == 0) ? 0 : (edges - 1) / 2) : edges / 2;
    if (idx > DATA_W - 1) idx = DATA_W - 1;
    miso_slave = slave_word[DATA_W-1-idx];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setConfig(input logic cp, input logic ph, input int sel, input int dv,
                           input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] sw, input int mode);
    cpol       = cp;
    cpha       = ph;
    cs_sel     = SEL_W'(sel);
    div        = DIV_W'(dv);
    tx_data    = tx;
    cpha_m     = ph;
    sel_m      = sel;
    slave_word = sw;
    miso_mode  = mode;
    exp_cpol   = cp;
    exp_div    = dv;
    exp_sel    = sel;
    exp_tx     = tx;
    exp_sw     = sw;
    exp_mode   = mode;
  endtask

  task automatic applyStimulus(input logic cp, input logic ph, input int sel, input int dv,
                               input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] sw, input int mode);
    @(negedge clock);
    #1;
    setConfig(cp, ph, sel, dv, tx, sw, mode);
    repeat (2) @(negedge clock);
    #1 start = 1'b1;
    @(negedge clock);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input int prev, input int budget);
    int n;
    n = 0;
    while (done_count == prev && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    n_checks++;
    assert (done_count != prev) else begin
      n_fail++;
      $error("[TB] FAIL done_timeout observed=no_done expected=done within %0d cycles", budget);
    end
  endtask

  task automatic checkXfer(input string tag);
    int h;
    int lat;
    logic [DATA_W-1:0] rx_exp;
    h   = exp_div + 1;
    lat = (2 * DATA_W + 2) * h;
    rx_exp = (exp_mode == MISO_LOOP) ? exp_tx : (exp_mode == MISO_ONES) ? '1 : exp_sw;
    checkOutput({tag, "_rx"},       32'(last_rx), 32'(rx_exp));
    checkOutput({tag, "_mosi"},     32'(last_mosi_word), 32'(exp_tx));
    checkOutput({tag, "_latency"},  last_latency, lat);
    checkOutput({tag, "_edges"},    last_edges, 2 * DATA_W);
    checkOutput({tag, "_cs_low"},   last_cs_low, (exp_sel < NUM_CS) ? lat : 0);
    checkOutput({tag, "_cs_other"}, 32'(last_other_low), 32'(1'b0));
    checkOutput({tag, "_sck_idle"}, 32'(last_sck), 32'(exp_cpol));
    @(negedge clock);
    #1;
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'(1'b0));
    checkOutput({tag, "_cs_idle"},    32'(spi_cs_n), 32'({NUM_CS{1'b1}}));
  endtask

  task automatic runXfer(input string tag, input logic cp, input logic ph, input int sel, input int dv,
                         input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] sw, input int mode);
    int prev;
    prev = done_count;
    applyStimulus(cp, ph, sel, dv, tx, sw, mode);
    waitDone(prev, (2 * DATA_W + 2) * (dv + 1) + 50);
    checkXfer(tag);
  endtask

  initial begin
    int prev;
    int rc;
    int n;
    reset   = 1'b1;
    start   = 1'b0;
    cpol    = 1'b0;
    cpha    = 1'b0;
    cs_sel  = '0;
    div     = '0;
    tx_data = '0;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'(1'b0));
    checkOutput("reset_done", 32'(done), 32'(1'b0));
    checkOutput("reset_rx",   32'(rx_data), 32'(0));
    checkOutput("reset_sck",  32'(spi_sck), 32'(1'b0));
    checkOutput("reset_mosi", 32'(spi_mosi), 32'(1'b0));
    checkOutput("reset_cs",   32'(spi_cs_n), 32'({NUM_CS{1'b1}}));
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Mode 0, fastest clock, loopback
    runXfer("mode0_loop", 1'b0, 1'b0, 1, 0, 8'hA5, 8'h00, MISO_LOOP);

    // All four modes against the slave model
    runXfer("mode0", 1'b0, 1'b0, 0, 3, 8'h3C, 8'hC3, MISO_SLAVE);
    runXfer("mode1", 1'b0, 1'b1, 1, 3, 8'h3C, 8'hC3, MISO_SLAVE);
    runXfer("mode2", 1'b1, 1'b0, 2, 3, 8'h3C, 8'hC3, MISO_SLAVE);
    runXfer("mode3", 1'b1, 1'b1, 0, 3, 8'h3C, 8'hC3, MISO_SLAVE);

    // Back-to-back with start held high
    prev = done_count;
    rc   = rise_count;
    @(negedge clock);
    #1;
    setConfig(1'b0, 1'b0, 1, 0, 8'h12, 8'h00, MISO_LOOP);
    repeat (2) @(negedge clock);
    #1 start = 1'b1;
    @(negedge clock);
    #1 tx_data = 8'h34;
    waitDone(prev, 200);
    checkOutput("b2b_first_rx",   32'(last_rx), 32'(8'h12));
    checkOutput("b2b_first_mosi", 32'(last_mosi_word), 32'(8'h12));
    prev = done_count;
    @(negedge clock);
    #1 start = 1'b0;
    waitDone(prev, 200);
    checkOutput("b2b_second_rx",      32'(last_rx), 32'(8'h34));
    checkOutput("b2b_second_mosi",    32'(last_mosi_word), 32'(8'h34));
    checkOutput("b2b_second_latency", last_latency, 2 * DATA_W + 2);
    checkOutput("b2b_cs_gap",         last_gap, 1);
    checkOutput("b2b_accepts",        rise_count - rc, 2);
    repeat (3) @(negedge clock);

    // Start pulses and configuration changes while busy are ignored
    prev = done_count;
    rc   = rise_count;
    applyStimulus(1'b0, 1'b1, 2, 1, 8'h5A, 8'h96, MISO_SLAVE);
    repeat (5) @(negedge clock);
    #1;
    start   = 1'b1;
    tx_data = 8'hFF;
    cpol    = 1'b1;
    cpha    = 1'b0;
    div     = '0;
    cs_sel  = '0;
    @(negedge clock);
    #1 start = 1'b0;
    repeat (10) @(negedge clock);
    #1 start = 1'b1;
    @(negedge clock);
    #1 start = 1'b0;
    waitDone(prev, 200);
    checkXfer("ignore");
    repeat (3) @(negedge clock);
    #1;
    checkOutput("ignore_single_accept", rise_count - rc, 1);
    checkOutput("ignore_idle_busy",     32'(busy), 32'(1'b0));

    // Reset in the middle of a transfer
    prev = done_count;
    applyStimulus(1'b0, 1'b0, 0, 2, 8'h77, 8'h11, MISO_SLAVE);
    n = 0;
    while (edges < 7 && n < 1000) begin
      @(negedge clock);
      #1;
      n++;
    end
    checkOutput("abort_reached_edge7", 32'(edges >= 7), 32'(1'b1));
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_cs",   32'(spi_cs_n), 32'({NUM_CS{1'b1}}));
    checkOutput("abort_sck",  32'(spi_sck), 32'(1'b0));
    checkOutput("abort_busy", 32'(busy), 32'(1'b0));
    checkOutput("abort_rx",   32'(rx_data), 32'(0));
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    checkOutput("abort_no_done", done_count - prev, 0);
    runXfer("post_reset", 1'b0, 1'b0, 0, 1, 8'hE1, 8'h5C, MISO_SLAVE);

    // Randomized transfers
    for (int k = 0; k < 6; k++) begin
      runXfer($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, NUM_CS - 1)), int'($urandom_range(0, 3)),
              8'($urandom), 8'($urandom), int'($urandom_range(0, 1)));
    end

    // Out-of-range select with the slowest divider
    runXfer("nocs_div255", 1'b0, 1'b0, NUM_CS, 255, 8'hC6, 8'h00, MISO_ONES);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_multi.md
SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning bits per transfer (legal 2..32).
REQ-002 The block SHALL have parameter NUM_CS, default 4, meaning number of chip-select lines (legal 1..16).
REQ-003 The block SHALL have parameter DIV_W, default 8, meaning width of the SCK divider input.
REQ-004 Port CLOCK  in  1  system clock; all logic on its rising edge.
REQ-005 Port RESET  in  1  asynchronous, active-high reset.
REQ-006 Port I_start  in  1  transfer request, sampled in IDLE only.
REQ-007 Port I_cpol  in  1  SCK idle level.
REQ-008 Port I_cpha  in  1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-009 Port I_cs_sel  in  max(1,$clog2(NUM_CS))  index of the chip select to assert.
REQ-010 Port I_div  in  DIV_W  SCK half-period, equal to I_div+1 CLOCK cycles.
REQ-011 Port I_tx_data  in  DATA_W  word to shift out, MSB first.
REQ-012 Port O_rx_data  out  DATA_W  last received word, MSB first.
REQ-013 Port O_busy  out  1  high from start acceptance until done.
REQ-014 Port O_done  out  1  one-cycle pulse at transfer completion.
REQ-015 Port I_spi_miso  in  1  serial data from slave.
REQ-016 Port O_spi_sck  out  1  SPI clock.
REQ-017 Port O_spi_cs_n  out  NUM_CS  active-low chip selects.
REQ-018 Port O_spi_mosi  out  1  serial data to slave.

Function
REQ-019 The block SHALL implement FSM states IDLE -> LEAD -> XFER -> TRAIL -> IDLE.
REQ-020 In IDLE with I_start=1 (cycle T0), the block SHALL latch I_cpol, I_cpha, I_cs_sel, I_div and I_tx_data, and enter LEAD with O_busy=1 at T0+1.
REQ-021 Changes to the configuration inputs during a transfer SHALL have no effect on it.
REQ-022 I_start outside IDLE SHALL be ignored (no queuing).
REQ-023 LEAD SHALL assert O_spi_cs_n[sel]=0, hold SCK at CPOL for H=I_div+1 cycles, and, when CPHA=0, drive MOSI = tx[DATA_W-1] on entry.
REQ-024 XFER SHALL produce exactly 2*DATA_W SCK edges, each spaced H cycles apart, with the first edge H cycles after LEAD entry.
REQ-025 When CPHA=0, XFER SHALL sample MISO on odd edges and shift MOSI on even edges, except the last edge.
REQ-026 When CPHA=1, XFER SHALL shift MOSI on odd edges (first shift drives the MSB) and sample MISO on even edges.
REQ-027 TRAIL SHALL hold SCK at CPOL and keep CS asserted for H cycles, then deassert all CS.
REQ-028 The block SHALL return to IDLE, and on that same cycle raise O_done for 1 cycle, drop O_busy, and update O_rx_data.
REQ-029 Completion latency SHALL be done at T0+1+(2*DATA_W+2)*H.
REQ-030 I_start asserted in the O_done cycle SHALL be accepted, giving back-to-back transfers with CS high for at least 1 cycle between them.
REQ-031 I_cs_sel >= NUM_CS SHALL keep all CS high while the transfer still runs and completes normally.
REQ-032 In IDLE, O_spi_sck SHALL follow I_cpol registered, all CS SHALL be high, and MOSI SHALL hold its last value.
REQ-033 O_rx_data SHALL change only on O_done.
REQ-034 An I_div of all-ones SHALL be supported without counter overflow, i.e. H = 2^DIV_W.

Reset
REQ-035 On RESET=1, the block SHALL immediately, asynchronously, set state IDLE, O_busy=0, O_done=0, O_rx_data=0, O_spi_sck=0, O_spi_mosi=0, O_spi_cs_n all ones, and clear the shift and edge counters.
REQ-036 RESET during a transfer SHALL abort it with no O_done and no O_rx_data update.
REQ-037 After reset release, the first I_start SHALL be accepted normally.

Verification
REQ-038 Mode 0, DATA_W=8, I_div=0, tx=0xA5, MISO loopback to MOSI -> O_done at T0+19, O_rx_data=0xA5, 16 SCK edges, CS[sel] low for 18 cycles.
REQ-039 All four CPOL/CPHA modes with I_div=3, tx=0x3C, slave model returning 0xC3 -> rx=0xC3 in every mode, SCK idle equal to CPOL, sampling edges as specified in REQ-025/026.
REQ-040 Back-to-back: I_start held high across two transfers with tx 0x12 then 0x34 -> two O_done pulses, CS high for exactly 1 cycle between them, both words received.
REQ-041 I_start pulsed while busy, plus I_tx_data changed mid-transfer -> ignored; transmitted word equals the value latched at T0.
REQ-042 RESET asserted after edge 7 -> all CS high and SCK=0 immediately, no O_done, O_rx_data=0; a following transfer completes correctly.
REQ-043 I_cs_sel=NUM_CS with I_div=255 -> no CS asserts, H=256, O_done at T0+1+18*256.
